mem_req_arbiter: RTL

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/mem_req_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory controller port.
// Latches the winning request, pulses ce, and waits for busy to rise and fall or for a start timeout.
module mem_req_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  IN_req_valid,
    input  logic [1:0]  IN_req_we,
    input  logic [19:0] IN_req_sramAddr,
    input  logic [59:0] IN_req_extAddr,
    output logic [1:0]  OUT_req_ready,
    output logic [1:0]  OUT_req_done,
    output logic        OUT_MC_ce,
    output logic        OUT_MC_we,
    output logic        OUT_MC_cacheID,
    output logic [9:0]  OUT_MC_sramAddr,
    output logic [29:0] OUT_MC_extAddr,
    input  logic        IN_MC_busy,
    output logic        OUT_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] start_cnt;
    logic       last_grant;
    logic       winner;
    logic       accept;
    logic       timeout_hit;

    // Round-robin: on contention the requester that did not win last time goes first.
    always_comb begin
        case (IN_req_valid)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_grant;
            default: winner = 1'b0;
        endcase
    end

    assign accept      = (state == IDLE) && (IN_req_valid != 2'b00);
    assign timeout_hit = (state == WAIT_START) && !IN_MC_busy && (start_cnt == 8'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (accept) state_next = ISSUE;
            ISSUE:      state_next = WAIT_START;
            WAIT_START: begin
                if (IN_MC_busy)       state_next = WAIT_DONE;
                else if (timeout_hit) state_next = IDLE;
            end
            WAIT_DONE:  if (!IN_MC_busy) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // ready/done are gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        OUT_req_ready = 2'b00;
        OUT_req_done  = 2'b00;
        OUT_MC_ce     = rst_n && (state == ISSUE);
        if (rst_n && accept) begin
            OUT_req_ready[winner] = 1'b1;
        end
        if (rst_n && (((state == WAIT_DONE) && !IN_MC_busy) || timeout_hit)) begin
            OUT_req_done[OUT_MC_cacheID] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_cnt       <= 8'd0;
            last_grant      <= 1'b1;
            OUT_err         <= 1'b0;
            OUT_MC_we       <= 1'b0;
            OUT_MC_cacheID  <= 1'b0;
            OUT_MC_sramAddr <= 10'd0;
            OUT_MC_extAddr  <= 30'd0;
        end else begin
            if (accept) begin
                last_grant      <= winner;
                OUT_MC_cacheID  <= winner;
                OUT_MC_we       <= IN_req_we[winner];
                OUT_MC_sramAddr <= winner ? IN_req_sramAddr[19:10] : IN_req_sramAddr[9:0];
                OUT_MC_extAddr  <= winner ? IN_req_extAddr[59:30] : IN_req_extAddr[29:0];
            end
            // start_cnt reads 1 in the first WAIT_START cycle.
            if (state == ISSUE) begin
                start_cnt <= 8'd1;
            end else if ((state == WAIT_START) && !IN_MC_busy && !timeout_hit) begin
                start_cnt <= start_cnt + 8'd1;
            end else begin
                start_cnt <= 8'd0;
            end
            if (timeout_hit) begin
                OUT_err <= 1'b1;
            end
        end
    end

endmodule
